// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared constants and helpers for input conditioning blocks
package input_conditioner_pkg;

    localparam int SYNC_MIN_DEPTH = 2;

    // Counter must hold 0..debounce_cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int debounce_cycles);
        return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw input / conditioned level and strobe bundle
interface input_conditioner_if #(
    parameter int WIDTH = 1
);

    logic [WIDTH-1:0] bits_in;
    logic [WIDTH-1:0] bits_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    modport master (
        output bits_in,
        input  bits_out,
        input  rise,
        input  fall
    );

    modport slave (
        input  bits_in,
        output bits_out,
        output rise,
        output fall
    );

endinterface

// File: rtl/input_conditioner_channel.sv
// rtl/input_conditioner_channel.sv - one channel: synchroniser, debounce, edge strobes (INPUT_CONDITIONER_EDGE_EN)
module input_conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int EXTRA_DEPTH     = 0,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter bit RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bit_in,
    output logic bit_out,
    output logic rise,
    output logic fall
);

    localparam int DEPTH = SYNC_MIN_DEPTH + EXTRA_DEPTH;
    localparam int CW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // First stage samples the asynchronous pin and may go metastable.
    (* ASYNC_REG = "TRUE", false_path = "TRUE" *) logic meta;
    logic [DEPTH-2:0] chain;
    logic             sync;
    logic             level;
    logic [CW-1:0]    cnt;
    logic             flip;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta  <= RESET_BIT;
            chain <= {(DEPTH-1){RESET_BIT}};
        end else begin
            meta     <= bit_in;
            chain[0] <= meta;
            for (int i = 1; i < DEPTH - 1; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign sync = chain[DEPTH-2];
    assign flip = (sync != level) && (cnt == CNT_LAST);

    // Any cycle agreeing with the current level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= RESET_BIT;
            cnt   <= '0;
        end else if (sync == level) begin
            cnt <= '0;
        end else if (flip) begin
            level <= sync;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_out = level;

`ifdef INPUT_CONDITIONER_EDGE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= flip & sync;
            fall <= flip & ~sync;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - WIDTH independent synchronise+debounce channels; strobes with INPUT_CONDITIONER_EDGE_EN
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter int               EXTRA_DEPTH     = 0,
    parameter int               DEBOUNCE_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
    input logic                 clk,
    input logic                 reset_n,
    input_conditioner_if.slave  io
);

    logic [WIDTH-1:0] bits_out_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        input_conditioner_channel #(
            .EXTRA_DEPTH     (EXTRA_DEPTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[i])
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .bit_in  (io.bits_in[i]),
            .bit_out (bits_out_w[i]),
            .rise    (rise_w[i]),
            .fall    (fall_w[i])
        );
    end

    assign io.bits_out = bits_out_w;
    assign io.rise     = rise_w;
    assign io.fall     = fall_w;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    input_conditioner_if #(.WIDTH(4)) io ();

    input_conditioner #(
        .WIDTH           (4),
        .EXTRA_DEPTH     (0),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (4'b0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

`ifdef INPUT_CONDITIONER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            checks_passed++;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] edge_mask(input logic [3:0] m);
        return EDGE ? m : 4'h0;
    endfunction

    initial begin
        logic seen_high, seen_rise, seen_fall;

        // Reset held with all inputs high
        reset_n    = 1'b0;
        io.bits_in = 4'hF;
        repeat (3) cycle();
        check("reset_out",  32'(io.bits_out), 32'h0);
        check("reset_rise", 32'(io.rise),     32'h0);
        check("reset_fall", 32'(io.fall),     32'h0);
        reset_n = 1'b1;
        #1;
        check("release_out",  32'(io.bits_out), 32'h0);
        check("release_rise", 32'(io.rise),     32'h0);
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check($sformatf("rel_out_%0d", k),  32'(io.bits_out), (k >= 6) ? 32'hF : 32'h0);
            check($sformatf("rel_rise_%0d", k), 32'(io.rise),     (k == 6) ? 32'(edge_mask(4'hF)) : 32'h0);
        end

        // All channels fall together
        io.bits_in = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check($sformatf("drop_out_%0d", k),  32'(io.bits_out), (k >= 6) ? 32'h0 : 32'hF);
            check($sformatf("drop_fall_%0d", k), 32'(io.fall),     (k == 6) ? 32'(edge_mask(4'hF)) : 32'h0);
        end

        // Latency on channel 0: D + DEBOUNCE_CYCLES = 6 edges
        io.bits_in = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check($sformatf("lat_out_%0d", k),  32'(io.bits_out[0]), 32'(k >= 6));
            check($sformatf("lat_rise_%0d", k), 32'(io.rise[0]),     32'(EDGE && (k == 6)));
        end

        // Glitch of 3 cycles on channel 1 is rejected
        seen_high = 1'b0; seen_rise = 1'b0; seen_fall = 1'b0;
        for (int k = 0; k < 12; k++) begin
            io.bits_in[1] = (k < 3);
            cycle();
            seen_high |= io.bits_out[1];
            seen_rise |= io.rise[1];
            seen_fall |= io.fall[1];
        end
        check("glitch3_high", 32'(seen_high), 32'h0);
        check("glitch3_rise", 32'(seen_rise), 32'h0);
        check("glitch3_fall", 32'(seen_fall), 32'h0);

        // Pulse of 4 cycles on channel 1 passes
        seen_high = 1'b0; seen_rise = 1'b0; seen_fall = 1'b0;
        for (int k = 0; k < 16; k++) begin
            io.bits_in[1] = (k < 4);
            cycle();
            seen_high |= io.bits_out[1];
            seen_rise |= io.rise[1];
            seen_fall |= io.fall[1];
        end
        check("pulse4_high", 32'(seen_high),       32'h1);
        check("pulse4_rise", 32'(seen_rise),       32'(EDGE));
        check("pulse4_fall", 32'(seen_fall),       32'(EDGE));
        check("pulse4_end",  32'(io.bits_out[1]),  32'h0);

        // Count restart on channel 2: high 3, low 1, then held high
        for (int k = 1; k <= 11; k++) begin
            io.bits_in[2] = (k <= 3) || (k >= 5);
            cycle();
            check($sformatf("restart_out_%0d", k),  32'(io.bits_out[2]), 32'(k >= 10));
            check($sformatf("restart_rise_%0d", k), 32'(io.rise[2]),     32'(EDGE && (k == 10)));
        end

        // Reset while channel 3 is mid-count
        io.bits_in[3] = 1'b1;
        repeat (4) cycle();
        check("midrst_pre_out", 32'(io.bits_out), 32'h5);
        reset_n = 1'b0;
        #1;
        check("midrst_out",  32'(io.bits_out), 32'h0);
        check("midrst_rise", 32'(io.rise),     32'h0);
        check("midrst_fall", 32'(io.fall),     32'h0);
        repeat (2) cycle();
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cycle();
            check($sformatf("midrel_out_%0d", k),  32'(io.bits_out), (k >= 6) ? 32'hD : 32'h0);
            check($sformatf("midrel_rise_%0d", k), 32'(io.rise),     (k == 6) ? 32'(edge_mask(4'hD)) : 32'h0);
            check($sformatf("midrel_fall_%0d", k), 32'(io.fall),     32'h0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
